fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Sits directly downstream of the line-drawing accelerator.
- Merges accelerator pixel writes (XL_*) with CPU direct pixel writes into the single frame-buffer write port.
- The accelerator has no backpressure, so XL always wins arbitration.
- CPU writes are buffered in a small FIFO and drained on cycles when XL is idle.

Parameters:
- mem_width, 1: pixel data width in bits.
- mem_depth, 786432: number of valid frame-buffer pixels (1024x768).
- mem_addr_width, `log2(mem_depth) = 20: address width.
- fifo_depth, 8: CPU write FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- XL_wr_en  in  1  accelerator write strobe. Every asserted cycle is one write and must be accepted.
- XL_wr_data  in  mem_width  accelerator pixel data.
- XL_wr_addr  in  mem_addr_width  accelerator pixel address.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept a CPU write this cycle.
- cpu_wr_data  in  mem_width  CPU pixel data.
- cpu_wr_addr  in  mem_addr_width  CPU pixel address.
- fb_wr_en  out  1  frame-buffer write strobe (registered).
- fb_wr_data  out  mem_width  frame-buffer write data (registered).
- fb_wr_addr  out  mem_addr_width  frame-buffer write address (registered).
- idle  out  1  FIFO empty and fb_wr_en low.

Behaviour:
- Reset, asynchronous on rst_n low:
  - fb_wr_en=0, fb_wr_data=0, fb_wr_addr=0.
  - FIFO pointers and count = 0.
  - cpu_wr_ready=1 once rst_n is high; held 0 while rst_n is low.
  - idle=1.
  - Reset mid-operation discards all buffered CPU writes. No partial write is emitted.
- Push: a CPU write is pushed when cpu_wr_valid && cpu_wr_ready.
  - cpu_wr_ready = (count != fifo_depth), combinational from the count register.
  - When full, no push occurs even if a pop happens the same cycle. Ready rises the cycle after the count drops.
- Arbitration, each cycle:
  - If XL_wr_en: register the XL write onto fb_* at the next edge.
  - Else if FIFO is non-empty: pop the head and register it onto fb_*.
  - Else: fb_wr_en=0 at the next edge; fb_wr_data and fb_wr_addr hold their last values.
- Latency:
  - XL: 1 cycle, input to fb_wr_en.
  - CPU with XL idle and FIFO empty: 2 cycles (push cycle, then pop cycle).
- No bypass path. A push and a pop in the same cycle are legal when 0 < count < fifo_depth; count is unchanged.
- FIFO pointers are log2(fifo_depth) bits and wrap modulo fifo_depth. Count is log2(fifo_depth)+1 bits.
- Ordering:
  - CPU writes are emitted in acceptance order.
  - XL writes are emitted in arrival order.
  - An XL write may overtake an already-buffered CPU write, including to the same address. This is a documented hazard, not corrected.
- Starvation: continuous XL_wr_en starves the FIFO indefinitely. CPU writes are stalled via cpu_wr_ready, never dropped.
- idle = (count==0) && !fb_wr_en, from registered state.

Optional Feature:
- Macro FB_ADDR_CHECK_EN.
- When defined:
  - Any write, XL or CPU, whose address is >= mem_depth is dropped at the arbitration stage. fb_wr_en stays 0 for that slot; a CPU entry is still popped.
  - A 16-bit saturating output port oob_count (reset 0) increments once per dropped write.
- When undefined:
  - No check; addresses pass through unmodified.
  - The oob_count port does not exist.

Test Plan:
- XL only: XL_wr_en high 3 cycles, addr 0,1,2, data 1 -> fb_wr_en high on cycles 1-3 with addr 0,1,2; CPU FIFO untouched; idle=1 after cycle 4.
- CPU only, XL idle: one CPU write, addr 1000, data 1 -> fb_wr_en exactly 2 cycles after acceptance, addr 1000; idle returns to 1.
- Fill and stall: XL_wr_en held high, 9 CPU writes offered, addrs 10..18 -> first 8 accepted, cpu_wr_ready=0 on the 9th, fb_* shows only XL. Drop XL -> addrs 10..17 emitted in order over 8 consecutive cycles; the 9th write (addr 18) is accepted the cycle ready rises.
- Interleave: XL_wr_en toggles every cycle while FIFO holds addrs 20,21,22 -> fb_* alternates XL, 20, XL, 21, XL, 22; no lost or duplicated writes.
- Reset mid-drain: FIFO holding 5 entries, rst_n low 1 cycle -> fb_wr_en=0 immediately, count=0, no buffered entry appears after release.
- FB_ADDR_CHECK_EN: XL addr 786432 and CPU addr 800000 -> no fb_wr_en for either, oob_count=2; XL addr 786431 -> written normally.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: merges accelerator (XL) pixel writes with buffered CPU
// pixel writes onto one registered frame-buffer write port. XL always wins;
// CPU writes wait in a small FIFO and drain on XL-idle cycles.
// Optional build macro FB_ADDR_CHECK_EN drops out-of-range writes and counts
// them on oob_count.
module fb_write_arbiter #(
    parameter int mem_width      = 1,
    parameter int mem_depth      = 786432,
    parameter int mem_addr_width = $clog2(mem_depth),
    parameter int fifo_depth     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      XL_wr_en,
    input  logic [mem_width-1:0]      XL_wr_data,
    input  logic [mem_addr_width-1:0] XL_wr_addr,
    input  logic                      cpu_wr_valid,
    output logic                      cpu_wr_ready,
    input  logic [mem_width-1:0]      cpu_wr_data,
    input  logic [mem_addr_width-1:0] cpu_wr_addr,
    output logic                      fb_wr_en,
    output logic [mem_width-1:0]      fb_wr_data,
    output logic [mem_addr_width-1:0] fb_wr_addr,
    output logic                      idle
`ifdef FB_ADDR_CHECK_EN
    ,
    output logic [15:0]               oob_count
`endif
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(fifo_depth);

    // FIFO storage carries no reset: only pointers/count define validity.
    logic [mem_width-1:0]      data_mem_q [fifo_depth];
    logic [mem_addr_width-1:0] addr_mem_q [fifo_depth];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic                      fb_en_q,   fb_en_d;
    logic [mem_width-1:0]      fb_data_q, fb_data_d;
    logic [mem_addr_width-1:0] fb_addr_q, fb_addr_d;

    logic                      push, pop;
    logic                      sel_vld;
    logic [mem_width-1:0]      sel_data;
    logic [mem_addr_width-1:0] sel_addr;

    // Ready depends only on the registered count, so a pop cannot free a
    // slot for a push in the same cycle; held low during reset.
    assign cpu_wr_ready = rst_n && (count_q != FULL);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = !XL_wr_en && (count_q != '0);

    // Arbitration source select: XL has no backpressure and always wins.
    always_comb begin
        sel_vld  = 1'b0;
        sel_data = fb_data_q;
        sel_addr = fb_addr_q;
        if (XL_wr_en) begin
            sel_vld  = 1'b1;
            sel_data = XL_wr_data;
            sel_addr = XL_wr_addr;
        end else if (pop) begin
            sel_vld  = 1'b1;
            sel_data = data_mem_q[rd_ptr_q];
            sel_addr = addr_mem_q[rd_ptr_q];
        end
    end

`ifdef FB_ADDR_CHECK_EN
    logic        in_range;
    logic        drop;
    logic [15:0] oob_q, oob_d;

    assign in_range = ({1'b0, sel_addr} < (mem_addr_width+1)'(mem_depth));
    assign drop     = sel_vld && !in_range;

    // Saturating count of writes dropped for an out-of-range address.
    always_comb begin
        oob_d = oob_q;
        if (drop && (oob_q != 16'hFFFF)) begin
            oob_d = oob_q + 16'd1;
        end
    end

    // Out-of-range counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= '0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign oob_count = oob_q;
`else
    logic in_range;
    assign in_range = 1'b1;
`endif

    // Output next-state: data/address hold their last values on idle slots.
    always_comb begin
        fb_en_d   = sel_vld && in_range;
        fb_data_d = fb_data_q;
        fb_addr_d = fb_addr_q;
        if (fb_en_d) begin
            fb_data_d = sel_data;
            fb_addr_d = sel_addr;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap modulo depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write on accepted CPU requests.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= cpu_wr_data;
            addr_mem_q[wr_ptr_q] <= cpu_wr_addr;
        end
    end

    // FIFO control registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Registered frame-buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_en_q   <= 1'b0;
            fb_data_q <= '0;
            fb_addr_q <= '0;
        end else begin
            fb_en_q   <= fb_en_d;
            fb_data_q <= fb_data_d;
            fb_addr_q <= fb_addr_d;
        end
    end

    assign fb_wr_en   = fb_en_q;
    assign fb_wr_data = fb_data_q;
    assign fb_wr_addr = fb_addr_q;
    assign idle       = (count_q == '0) && !fb_en_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter. Expected frame-buffer outputs are
// pushed to a scoreboard queue as each cycle's stimulus is driven, then popped
// and compared after the clock edge. Build with FB_ADDR_CHECK_EN to also
// exercise the address-range check.
module tb_fb_write_arbiter;

    localparam int W     = 1;
    localparam int DEPTH = 786432;
    localparam int AW    = 20;
    localparam int D     = 8;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          idle;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          XL_wr_en = 1'b0;
    logic [W-1:0]  XL_wr_data = '0;
    logic [AW-1:0] XL_wr_addr = '0;
    logic          cpu_wr_valid = 1'b0;
    logic          cpu_wr_ready;
    logic [W-1:0]  cpu_wr_data = '0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic          fb_wr_en;
    logic [W-1:0]  fb_wr_data;
    logic [AW-1:0] fb_wr_addr;
    logic          idle;
`ifdef FB_ADDR_CHECK_EN
    logic [15:0]   oob_count;
    int            m_oob = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exp_t          exp_q[$];
    ent_t          mq[$];
    logic [AW-1:0] last_a = '0;
    logic [W-1:0]  last_d = '0;

    fb_write_arbiter #(
        .mem_width(W), .mem_depth(DEPTH), .mem_addr_width(AW), .fifo_depth(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .XL_wr_en(XL_wr_en), .XL_wr_data(XL_wr_data), .XL_wr_addr(XL_wr_addr),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_addr(cpu_wr_addr),
        .fb_wr_en(fb_wr_en), .fb_wr_data(fb_wr_data), .fb_wr_addr(fb_wr_addr),
        .idle(idle)
`ifdef FB_ADDR_CHECK_EN
        , .oob_count(oob_count)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, predict the next registered output, push
    // the prediction, and advance past the active edge.
    task automatic drive_cycle(input logic xl, input logic [AW-1:0] xa, input logic [W-1:0] xd,
                               input logic cv, input logic [AW-1:0] ca, input logic [W-1:0] cd,
                               output logic rdy_obs, output logic rdy_exp);
        exp_t e;
        ent_t h;
        logic had;
        @(negedge clk);
        XL_wr_en = xl; XL_wr_addr = xa; XL_wr_data = xd;
        cpu_wr_valid = cv; cpu_wr_addr = ca; cpu_wr_data = cd;
        #1;
        rdy_obs = cpu_wr_ready;
        rdy_exp = (mq.size() != D);
        had = (mq.size() != 0);
        e.en = 1'b0; e.addr = '0; e.data = '0;
        if (xl) begin
            e.en = 1'b1; e.addr = xa; e.data = xd;
        end else if (had) begin
            h = mq.pop_front();
            e.en = 1'b1; e.addr = h.addr; e.data = h.data;
        end
        if (cv && rdy_exp) mq.push_back('{ca, cd});
`ifdef FB_ADDR_CHECK_EN
        if (e.en && (e.addr >= DEPTH)) begin
            e.en = 1'b0;
            if (m_oob != 65535) m_oob++;
        end
`endif
        if (e.en) begin
            last_a = e.addr; last_d = e.data;
        end
        e.addr = last_a; e.data = last_d;
        e.idle = (mq.size() == 0) && !e.en;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (cpu_wr_ready !== 1'b0 || fb_wr_en !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hold: ready=%0b en=%0b idle=%0b, want ready=0 en=0 idle=1", cpu_wr_ready, fb_wr_en, idle);
        end
        n_checks++;
        if (fb_wr_addr !== '0 || fb_wr_data !== '0) begin
            n_errors++;
            $display("FAIL reset_data: addr=%0d data=%0h, want 0 0", fb_wr_addr, fb_wr_data);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cpu_wr_ready !== 1'b1 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: ready=%0b idle=%0b, want 1 1", cpu_wr_ready, idle);
        end
    endtask

    task automatic test_xl_only();
        exp_t e;
        logic ro, re;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i < 3, AW'(i), 1'b1, 1'b0, '0, '0, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL xl_only[%0d]: en=%0b addr=%0d data=%0h idle=%0b, want en=%0b addr=%0d data=%0h idle=%0b",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, idle, e.en, e.addr, e.data, e.idle);
            end
        end
    endtask

    task automatic test_cpu_only();
        exp_t e;
        logic ro, re;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, '0, i == 0, AW'(1000), 1'b1, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL cpu_only[%0d]: en=%0b addr=%0d data=%0h idle=%0b, want en=%0b addr=%0d data=%0h idle=%0b",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, idle, e.en, e.addr, e.data, e.idle);
            end
            if (i == 1) begin
                n_checks++;
                if (fb_wr_en !== 1'b1 || fb_wr_addr !== AW'(1000)) begin
                    n_errors++;
                    $display("FAIL cpu_latency: en=%0b addr=%0d, want en=1 addr=1000 two cycles after accept", fb_wr_en, fb_wr_addr);
                end
            end
        end
    endtask

    task automatic test_fill_stall();
        exp_t e;
        logic ro, re, pend;
        int   n_acc, acc_at;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, AW'(500 + i), W'(i), 1'b1, AW'(10 + i), 1'b1, ro, re);
            if (ro) n_acc++;
            e = exp_q.pop_front();
            n_checks++;
            if (ro !== re || fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL fill[%0d]: ready=%0b en=%0b addr=%0d data=%0h idle=%0b, want ready=%0b en=%0b addr=%0d data=%0h idle=%0b",
                         i, ro, fb_wr_en, fb_wr_addr, fb_wr_data, idle, re, e.en, e.addr, e.data, e.idle);
            end
        end
        n_checks++;
        if (n_acc != 8) begin
            n_errors++;
            $display("FAIL fill_accepts: accepted=%0d, want 8", n_acc);
        end
        pend = 1'b1;
        acc_at = -1;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b0, '0, '0, pend, AW'(18), 1'b1, ro, re);
            if (pend && ro) begin
                acc_at = i; pend = 1'b0;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (ro !== re || fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL drain[%0d]: ready=%0b en=%0b addr=%0d data=%0h idle=%0b, want ready=%0b en=%0b addr=%0d data=%0h idle=%0b",
                         i, ro, fb_wr_en, fb_wr_addr, fb_wr_data, idle, re, e.en, e.addr, e.data, e.idle);
            end
            if (i < 8) begin
                n_checks++;
                if (fb_wr_en !== 1'b1 || fb_wr_addr !== AW'(10 + i)) begin
                    n_errors++;
                    $display("FAIL drain_order[%0d]: en=%0b addr=%0d, want en=1 addr=%0d", i, fb_wr_en, fb_wr_addr, 10 + i);
                end
            end
        end
        n_checks++;
        if (acc_at != 1) begin
            n_errors++;
            $display("FAIL ninth_accept: accepted on drain cycle %0d, want 1", acc_at);
        end
    endtask

    task automatic test_interleave();
        exp_t e;
        logic ro, re;
        for (int i = 0; i < 12; i++) begin
            if (i < 3) drive_cycle(1'b1, AW'(700 + i), 1'b0, 1'b1, AW'(20 + i), 1'b1, ro, re);
            else       drive_cycle(i[0], AW'(800 + i), 1'b1, 1'b0, '0, '0, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL interleave[%0d]: en=%0b addr=%0d data=%0h idle=%0b, want en=%0b addr=%0d data=%0h idle=%0b",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, idle, e.en, e.addr, e.data, e.idle);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic ro, re;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, AW'(900 + i), 1'b1, 1'b1, AW'(40 + i), 1'b1, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL preload[%0d]: en=%0b addr=%0d idle=%0b, want en=%0b addr=%0d idle=%0b",
                         i, fb_wr_en, fb_wr_addr, idle, e.en, e.addr, e.idle);
            end
        end
        @(negedge clk);
        XL_wr_en = 1'b0; cpu_wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fb_wr_en !== 1'b0 || fb_wr_addr !== '0 || idle !== 1'b1 || cpu_wr_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: en=%0b addr=%0d idle=%0b ready=%0b, want 0 0 1 0", fb_wr_en, fb_wr_addr, idle, cpu_wr_ready);
        end
        mq.delete(); exp_q.delete();
        last_a = '0; last_d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || idle !== e.idle || fb_wr_en !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset[%0d]: en=%0b addr=%0d idle=%0b, want en=0 addr=%0d idle=%0b",
                         i, fb_wr_en, fb_wr_addr, idle, e.addr, e.idle);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic ro, re;
        for (int i = 0; i < 220; i++) begin
            if (i < 200)
                drive_cycle($urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)), W'($urandom_range(0, 1)),
                            $urandom_range(0, 2) != 0, AW'($urandom_range(0, DEPTH - 1)), W'($urandom_range(0, 1)), ro, re);
            else
                drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, ro, re);
            e = exp_q.pop_front();
            n_checks++;
            if (ro !== re || fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL random[%0d]: ready=%0b en=%0b addr=%0d data=%0h idle=%0b, want ready=%0b en=%0b addr=%0d data=%0h idle=%0b",
                         i, ro, fb_wr_en, fb_wr_addr, fb_wr_data, idle, re, e.en, e.addr, e.data, e.idle);
            end
        end
    endtask

`ifdef FB_ADDR_CHECK_EN
    task automatic test_addr_check();
        exp_t e;
        logic ro, re;
        int   base;
        base = m_oob;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive_cycle(1'b1, AW'(786432), 1'b1, 1'b1, AW'(800000), 1'b1, ro, re);
                4:       drive_cycle(1'b1, AW'(786431), 1'b1, 1'b0, '0, '0, ro, re);
                default: drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, ro, re);
            endcase
            e = exp_q.pop_front();
            n_checks++;
            if (fb_wr_en !== e.en || fb_wr_addr !== e.addr || fb_wr_data !== e.data || idle !== e.idle) begin
                n_errors++;
                $display("FAIL addr_check[%0d]: en=%0b addr=%0d idle=%0b, want en=%0b addr=%0d idle=%0b",
                         i, fb_wr_en, fb_wr_addr, idle, e.en, e.addr, e.idle);
            end
        end
        n_checks++;
        if (oob_count !== 16'(base + 2) || m_oob != base + 2) begin
            n_errors++;
            $display("FAIL oob_count: got %0d, want %0d", oob_count, base + 2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_xl_only();
        test_cpu_only();
        test_fill_stall();
        test_interleave();
        test_reset_mid();
`ifdef FB_ADDR_CHECK_EN
        test_addr_check();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
